div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL implement the reset as decided: reset rst, synchronous, active-high.
REQ-002 The port list SHALL be, one per line, as follows (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  divide request from the execute stage, held high until ready_o is seen
- annul_i  in  1  abort request (pipeline flush)
- signed_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- result_o  out  64  {remainder[63:32], quotient[31:0]}, destined for HI/LO
- ready_o  out  1  result valid

Function
REQ-003 The block SHALL use a registered FSM with states FREE, BYZERO, ON and END.
REQ-004 In FREE with start_i=1 and annul_i=0, at the next edge the FSM SHALL go to BYZERO if opdata2_i==0, else to ON; otherwise it SHALL stay in FREE.
REQ-005 Operands SHALL be captured only on the FREE->ON/BYZERO edge; later operand changes SHALL be ignored.
REQ-006 Signed mode at capture:
- a negative dividend or divisor SHALL be replaced by its two's complement
- the original sign bits SHALL be latched
REQ-007 ON SHALL perform exactly 32 restoring shift-subtract steps, one per edge, using a 65-bit working register and a 6-bit step counter cleared at capture.
REQ-008 Each step SHALL form a 33-bit difference {0, working[63:32]} - {0, divisor}:
- difference non-negative: write it back, shift in quotient bit 1
- otherwise: shift only, quotient bit 0
REQ-009 After the 32nd step (counter==32), the next edge SHALL enter END and register the result.
REQ-010 Result sign correction in signed mode:
- quotient negated iff the dividend and divisor signs differ
- remainder negated iff the dividend was negative
- unsigned mode: no correction
REQ-011 Arithmetic SHALL wrap modulo 2^32; 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0.
REQ-012 BYZERO SHALL go to END on the next edge with result_o = 64'h0.
REQ-013 Latency: start accepted at edge k SHALL give ready_o=1 after edge k+34 for a non-zero divisor, and after edge k+2 for a zero divisor.
REQ-014 ready_o SHALL be 1 only in END; result_o SHALL hold its value for the whole time in END.
REQ-015 In END with start_i=1, the FSM SHALL stay in END; with start_i=0, the next edge SHALL enter FREE, and ready_o and result_o SHALL be 0.
REQ-016 annul_i=1 in ON or BYZERO SHALL send the FSM to FREE at the next edge, discard the partial result and keep ready_o=0.
REQ-017 annul_i=1 in FREE SHALL block acceptance of a new request.
REQ-018 start_i deasserting during ON SHALL NOT abort; only annul_i aborts.
REQ-019 annul_i and start_i both high in FREE: annul_i SHALL win.
REQ-020 Outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-021 rst=1 at an edge SHALL force:
- state FREE
- step counter 0, working register 0
- result_o = 64'h0, ready_o = 0
REQ-022 rst SHALL take priority over all other inputs in every state, including mid-ON and END.
REQ-023 Following deassertion of rst, the first request SHALL be accepted from FREE with the full 34-edge latency.

Verification
REQ-024 Unsigned 100 / 7, start held -> ready_o after 34 edges, result_o = {32'd2, 32'd14}.
REQ-025 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; start_i drop -> ready_o=0 next edge.
REQ-026 Divide by zero, 5 / 0 -> ready_o after 2 edges, result_o = 64'h0, held while start_i=1.
REQ-027 annul_i pulsed at step 10 of ON -> FREE next edge, ready_o never asserts; an immediate new request 9 / 3 -> {0, 3}.
REQ-028 Signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}; rst asserted mid-ON on a second request -> outputs 0 and state FREE next edge.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit divider controller: restoring shift-subtract division
// over 32 steps, with signed/unsigned modes, divide-by-zero shortcut and
// pipeline-flush abort. Result is {remainder, quotient} for HI/LO.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [64:0] working;
    logic [5:0]  step_cnt;
    logic [31:0] divisor;
    logic        neg_dividend;
    logic        neg_divisor;

    logic        accept;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] diff;
    logic [31:0] quotient_fix;
    logic [31:0] remainder_fix;

    // Operand preparation, one restoring step and final sign fix-up
    always_comb begin
        accept        = start_i && !annul_i;
        dividend_abs  = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        divisor_abs   = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        diff          = {1'b0, working[63:32]} - {1'b0, divisor};
        quotient_fix  = (neg_dividend ^ neg_divisor) ? (~working[31:0] + 32'd1) : working[31:0];
        remainder_fix = neg_dividend ? (~working[64:33] + 32'd1) : working[64:33];
    end

    // State register; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort only via annul, leave END when start drops
    always_comb begin
        next_state = state;
        case (state)
            FREE: begin
                if (accept) begin
                    next_state = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                next_state = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    next_state = FREE;
                end else if (step_cnt == 6'd32) begin
                    next_state = END;
                end
            end
            END: begin
                if (!start_i) begin
                    next_state = FREE;
                end
            end
            default: next_state = FREE;
        endcase
    end

    // Datapath and registered outputs: capture, iterate, correct, present
    always_ff @(posedge clk) begin
        if (rst) begin
            working      <= 65'd0;
            step_cnt     <= 6'd0;
            divisor      <= 32'd0;
            neg_dividend <= 1'b0;
            neg_divisor  <= 1'b0;
            result_o     <= 64'd0;
            ready_o      <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (accept) begin
                        working      <= {32'd0, dividend_abs, 1'b0};
                        divisor      <= divisor_abs;
                        step_cnt     <= 6'd0;
                        neg_dividend <= signed_i & opdata1_i[31];
                        neg_divisor  <= signed_i & opdata2_i[31];
                    end
                end
                BYZERO: begin
                    working  <= 65'd0;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
                ON: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (annul_i) begin
                        working  <= 65'd0;
                        step_cnt <= 6'd0;
                    end else if (step_cnt == 6'd32) begin
                        working  <= {remainder_fix, 1'b0, quotient_fix};
                        step_cnt <= 6'd0;
                    end else begin
                        if (diff[32]) begin
                            working <= {working[63:0], 1'b0};
                        end else begin
                            working <= {diff[31:0], working[31:0], 1'b1};
                        end
                        step_cnt <= step_cnt + 6'd1;
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_o  <= 1'b1;
                        result_o <= {working[64:33], working[31:0]};
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed/unsigned
// results, divide-by-zero, annul, reset priority and a small vector table.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    int pass_count = 0;
    int check_count = 0;

    div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, settling 1 ns after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        step(2);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL reset_ready got=%b exp=0", ready_o);
        else pass_count++;
        check_count++;
        if (result_o !== 64'd0) $display("[TB] FAIL reset_result got=%h exp=%h", result_o, 64'd0);
        else pass_count++;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_unsigned();
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        step(1);
        step(33);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL u100_7_early_ready got=%b exp=0", ready_o);
        else pass_count++;
        step(1);
        check_count++;
        if (ready_o !== 1'b1) $display("[TB] FAIL u100_7_ready got=%b exp=1", ready_o);
        else pass_count++;
        check_count++;
        if (result_o !== {32'd2, 32'd14}) $display("[TB] FAIL u100_7_result got=%h exp=%h", result_o, {32'd2, 32'd14});
        else pass_count++;
        step(3);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14})
            $display("[TB] FAIL u100_7_hold got=%b/%h exp=1/%h", ready_o, result_o, {32'd2, 32'd14});
        else pass_count++;
        start_i = 1'b0;
        step(1);
        check_count++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("[TB] FAIL u100_7_release got=%b/%h exp=0/0", ready_o, result_o);
        else pass_count++;
    endtask

    task automatic test_signed();
        signed_i = 1'b1; opdata1_i = 32'hFFFF_FFF9; opdata2_i = 32'd2; start_i = 1'b1;
        step(1);
        signed_i = 1'b0; opdata1_i = 32'd123; opdata2_i = 32'd0;
        step(5);
        start_i = 1'b0;
        step(10);
        start_i = 1'b1;
        step(18);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL s_m7_2_early_ready got=%b exp=0", ready_o);
        else pass_count++;
        step(1);
        check_count++;
        if (ready_o !== 1'b1) $display("[TB] FAIL s_m7_2_ready got=%b exp=1", ready_o);
        else pass_count++;
        check_count++;
        if (result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("[TB] FAIL s_m7_2_result got=%h exp=%h", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else pass_count++;
        start_i = 1'b0;
        step(1);
        check_count++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("[TB] FAIL s_m7_2_release got=%b/%h exp=0/0", ready_o, result_o);
        else pass_count++;
    endtask

    task automatic test_div_zero();
        signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        step(1);
        step(1);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL dz_early_ready got=%b exp=0", ready_o);
        else pass_count++;
        step(1);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== 64'd0)
            $display("[TB] FAIL dz_ready got=%b/%h exp=1/0", ready_o, result_o);
        else pass_count++;
        step(4);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== 64'd0)
            $display("[TB] FAIL dz_hold got=%b/%h exp=1/0", ready_o, result_o);
        else pass_count++;
        start_i = 1'b0;
        step(1);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL dz_release got=%b exp=0", ready_o);
        else pass_count++;
    endtask

    task automatic test_annul();
        logic seen;
        signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        step(1);
        step(10);
        annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        step(1);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL annul_on_ready got=%b exp=0", ready_o);
        else pass_count++;
        step(2);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL annul_free_ready got=%b exp=0", ready_o);
        else pass_count++;
        annul_i = 1'b0;
        step(1);
        seen = 1'b0;
        for (int i = 0; i < 33; i++) begin
            step(1);
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL annul_no_early_ready got=%b exp=0", seen);
        else pass_count++;
        step(1);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd3})
            $display("[TB] FAIL annul_9_3_result got=%b/%h exp=1/%h", ready_o, result_o, {32'd0, 32'd3});
        else pass_count++;
        start_i = 1'b0;
        step(1);
    endtask

    task automatic test_overflow_reset();
        signed_i = 1'b1; opdata1_i = 32'h8000_0000; opdata2_i = 32'hFFFF_FFFF; start_i = 1'b1;
        step(1);
        step(34);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== {32'h0, 32'h8000_0000})
            $display("[TB] FAIL ovf_result got=%b/%h exp=1/%h", ready_o, result_o, {32'h0, 32'h8000_0000});
        else pass_count++;
        start_i = 1'b0;
        step(1);
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        step(1);
        step(15);
        rst = 1'b1;
        step(1);
        check_count++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("[TB] FAIL rst_mid_on got=%b/%h exp=0/0", ready_o, result_o);
        else pass_count++;
        rst = 1'b0;
        step(1);
        step(33);
        check_count++;
        if (ready_o !== 1'b0) $display("[TB] FAIL rst_restart_early got=%b exp=0", ready_o);
        else pass_count++;
        step(1);
        check_count++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14})
            $display("[TB] FAIL rst_restart_result got=%b/%h exp=1/%h", ready_o, result_o, {32'd2, 32'd14});
        else pass_count++;
        rst = 1'b1;
        step(1);
        check_count++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("[TB] FAIL rst_in_end got=%b/%h exp=0/0", ready_o, result_o);
        else pass_count++;
        start_i = 1'b0;
        rst = 1'b0;
        step(1);
    endtask

    logic [31:0] vec_a   [7] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FF9C, 32'd3,
                                 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] vec_b   [7] = '{32'h0000_0010, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd5,
                                 32'hFFFF_FFFF, 32'd2, 32'hC000_0000};
    logic        vec_s   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] vec_exp [7] = '{{32'h0000_000F, 32'h0FFF_FFFF},
                                 {32'h0000_0001, 32'hFFFF_FFFD},
                                 {32'hFFFF_FFFE, 32'h0000_000E},
                                 {32'h0000_0003, 32'h0000_0000},
                                 {32'h8000_0000, 32'h0000_0000},
                                 {32'h0000_0001, 32'h7FFF_FFFC},
                                 {32'h3FFF_FFFF, 32'h0000_0001}};

    task automatic test_vectors();
        for (int i = 0; i < 7; i++) begin
            signed_i = vec_s[i]; opdata1_i = vec_a[i]; opdata2_i = vec_b[i]; start_i = 1'b1;
            step(1);
            step(34);
            check_count++;
            if (ready_o !== 1'b1 || result_o !== vec_exp[i])
                $display("[TB] FAIL vec%0d got=%b/%h exp=1/%h", i, ready_o, result_o, vec_exp[i]);
            else pass_count++;
            start_i = 1'b0;
            step(1);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_overflow_reset();
        test_vectors();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
